afifo_reader: RTL and testbench

- Single-clock consumer for the read side of the `afifo16` asynchronous FIFO; sits in the read-clock domain.
- Issues `rd_en` only when the FIFO is non-empty and local space is guaranteed.
- Absorbs the FIFO's one-cycle registered read latency in a 2-entry output buffer.
- Presents words on a valid/ready stream, with frame marking (`m_last_o`) every FRAME_LEN words and a running delivered-word count.

---
 rtl/afifo_reader.sv | 117 +++++++++++
 tb/tb_afifo_reader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/afifo_reader.sv
// afifo_reader: read-clock-domain consumer for the afifo16 FIFO.
// Credit-based reads, 2-deep skid buffer, valid/ready out, frame + word count.
//
// Ports:
//   clk_i          read-domain clock (same as FIFO rd_clk_i)
//   reset_i        asynchronous active-high reset
//   enable_i       gate for new FIFO reads (buffered words still drain)
//   fifo_rd_en_o   FIFO read strobe
//   fifo_rd_data_i FIFO read data, valid the cycle after fifo_rd_en_o
//   fifo_empty_i   FIFO empty flag
//   m_valid_o      output word valid
//   m_ready_i      downstream accept
//   m_data_o       oldest buffered word
//   m_last_o       last word of a FRAME_LEN-word frame
//   count_o        words delivered, wraps modulo 2^CNT_BITS
module afifo_reader #(
  parameter int WIDTH     = 18,
  parameter int FRAME_LEN = 16,
  parameter int CNT_BITS  = 16
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                enable_i,
  output logic                fifo_rd_en_o,
  input  logic [WIDTH-1:0]    fifo_rd_data_i,
  input  logic                fifo_empty_i,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic [WIDTH-1:0]    m_data_o,
  output logic                m_last_o,
  output logic [CNT_BITS-1:0] count_o
);

  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FW-1:0] LAST_IDX = FW'(FRAME_LEN - 1);

  logic [WIDTH-1:0]    r_buf [2];
  logic                r_wr_ptr;
  logic                r_rd_ptr;
  logic [1:0]          r_occ;
  logic                r_inflight;
  logic [FW-1:0]       r_frame_cnt;
  logic [CNT_BITS-1:0] r_count;

  logic                w_valid;
  logic                w_pop;
  logic                w_push;
  logic                w_frame_end;
  logic [2:0]          w_credit_use;

  assign w_valid     = (r_occ != 2'd0);
  assign w_pop       = w_valid & m_ready_i;
  assign w_push      = r_inflight;
  assign w_frame_end = (r_frame_cnt == LAST_IDX);

  // Slots committed after this edge: buffered + in flight - leaving now.
  // A new read is only safe if that leaves room for its data.
  assign w_credit_use = {1'b0, r_occ}
                      + {2'b00, r_inflight}
                      - {2'b00, w_pop};

  // Gated by reset so the strobe drops as soon as reset asserts.
  assign fifo_rd_en_o = ~reset_i
                      & enable_i
                      & ~fifo_empty_i
                      & (w_credit_use < 3'd2);

  assign m_valid_o = w_valid;
  // Forced to zero when idle so reset clears it without the edge.
  assign m_data_o  = w_valid ? r_buf[r_rd_ptr] : '0;
  assign m_last_o  = w_valid & w_frame_end;
  assign count_o   = r_count;

  // Buffer storage carries no reset; only occupancy says what is live.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_buf[r_wr_ptr] <= fifo_rd_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= fifo_rd_en_o;
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_frame_cnt <= '0;
      r_count     <= '0;
    end else if (w_pop) begin
      r_count <= r_count + CNT_BITS'(1);
      if (w_frame_end) begin
        r_frame_cnt <= '0;
      end else begin
        r_frame_cnt <= r_frame_cnt + FW'(1);
      end
    end
  end

endmodule

// File: tb/tb_afifo_reader.sv
// tb_afifo_reader: random-stimulus bench for afifo_reader.
// A queue-based FIFO and credit/latency scoreboard predict every cycle.
module tb_afifo_reader;

  localparam int W  = 18;
  localparam int FL = 16;
  localparam int CB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic          empty = 1'b1;
  logic          ready = 1'b0;
  logic [W-1:0]  rdata = '0;

  logic          rd_en, valid, last;
  logic [W-1:0]  data;
  logic [CB-1:0] count;
  logic          rd_en1, valid1, last1;
  logic [W-1:0]  data1;
  logic [CB-1:0] count1;

  afifo_reader #(.WIDTH(W), .FRAME_LEN(FL), .CNT_BITS(CB)) u_dut (
    .clk_i(clk), .reset_i(rst), .enable_i(en),
    .fifo_rd_en_o(rd_en), .fifo_rd_data_i(rdata),
    .fifo_empty_i(empty), .m_valid_o(valid), .m_ready_i(ready),
    .m_data_o(data), .m_last_o(last), .count_o(count)
  );

  afifo_reader #(.WIDTH(W), .FRAME_LEN(1), .CNT_BITS(CB)) u_dut1 (
    .clk_i(clk), .reset_i(rst), .enable_i(en),
    .fifo_rd_en_o(rd_en1), .fifo_rd_data_i(rdata),
    .fifo_empty_i(empty), .m_valid_o(valid1), .m_ready_i(ready),
    .m_data_o(data1), .m_last_o(last1), .count_o(count1)
  );

  typedef struct {
    logic [W-1:0] d;
    int           t;
  } ent_t;

  logic [W-1:0] fq[$];
  ent_t         sb[$];
  int cyc = 0;
  int delivered = 0;
  int vecs = 0;
  int errs = 0;
  int run = 0;
  int maxrun = 0;
  int nlast = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    logic ev, pop, rd;
    int   mod;
    @(negedge clk);
    empty = (fq.size() == 0);
    #1;
    mod = 1 << CB;
    ev  = (sb.size() != 0) && (sb[0].t + 2 <= cyc);
    pop = ev && ready;
    rd  = en && !empty && ((sb.size() - int'(pop)) < 2);
    chk("valid", valid, ev);
    chk("rd_en", rd_en, rd);
    chk("last", last, ev && (delivered % FL == FL - 1));
    chk("count", count, delivered % mod);
    if (ev) chk("data", data, sb[0].d);
    chk("valid_f1", valid1, ev);
    chk("rd_en_f1", rd_en1, rd);
    chk("last_f1", last1, ev);
    chk("count_f1", count1, delivered % mod);
    if (ev) chk("data_f1", data1, sb[0].d);
    if (ev) begin
      run++;
      if (run > maxrun) maxrun = run;
    end else begin
      run = 0;
    end
    if (pop && last) nlast++;
    @(posedge clk);
    #1;
    if (pop) begin
      void'(sb.pop_front());
      delivered++;
    end
    if (rd) begin
      rdata = fq.pop_front();
      sb.push_back('{d: rdata, t: cyc});
    end else begin
      rdata = W'($urandom);
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_rd_en", rd_en, 0);
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_last", last, 0);
    chk("rst_count", count, 0);
    sb.delete();
    delivered = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdata = W'($urandom);
    cyc++;
  endtask

  initial begin
    int pushed;
    do_reset();

    en = 1'b1;
    ready = 1'b1;
    for (int k = 0; k < 20; k++) step();

    fq.push_back(18'h030F0);
    for (int k = 0; k < 6; k++) step();
    chk("single_count", count, 1);

    do_reset();
    ready = 1'b0;
    for (int k = 0; k < 40; k++) fq.push_back(W'($urandom));
    ready = 1'b1;
    run = 0;
    maxrun = 0;
    nlast = 0;
    for (int k = 0; k < 46; k++) step();
    chk("stream_run", maxrun, 40);
    chk("stream_lasts", nlast, 2);
    chk("stream_count", count, 40);

    for (int k = 0; k < 10; k++) fq.push_back(W'($urandom));
    for (int k = 0; k < 32; k++) begin
      ready = (k % 4 == 0) || (k % 4 == 3);
      step();
    end
    chk("bp_count", count, 50);

    ready = 1'b1;
    for (int k = 0; k < 6; k++) fq.push_back(W'($urandom));
    for (int k = 0; k < 2; k++) step();
    en = 1'b0;
    for (int k = 0; k < 5; k++) step();
    en = 1'b1;
    for (int k = 0; k < 10; k++) step();
    for (int k = 0; k < 5; k++) fq.push_back(W'($urandom));
    for (int k = 0; k < 10; k++) step();
    chk("gap_count", count, 61);

    pushed = 0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 2) != 0 && pushed < 300) begin
        fq.push_back(W'($urandom));
        pushed++;
      end
      ready = ($urandom_range(0, 3) != 0);
      en = ($urandom_range(0, 7) != 0);
      step();
    end
    en = 1'b1;
    ready = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (fq.size() == 0 && sb.size() == 0) break;
      step();
    end
    chk("drain_left", fq.size() + sb.size(), 0);

    for (int k = 0; k < 8; k++) fq.push_back(W'($urandom));
    ready = 1'b0;
    for (int k = 0; k < 6; k++) step();
    chk("pre_rst_valid", valid, 1);
    do_reset();
    ready = 1'b1;
    for (int k = 0; k < 14; k++) step();
    chk("post_rst_count", count, 6);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
